// File: rtl/roll_sequencer_if.sv
// ---------------------------------------------------------------------------
// roll_sequencer_if
//   Groups the roll request / LFSR datapath / display signals of the roll
//   sequencer into one bundle. Clock and reset stay outside as plain ports.
//
//   i_start       start / restart roll request          (master -> slave)
//   i_lfsr_val    current LFSR state                    (master -> slave)
//   o_step        advance enable to the LFSR            (slave  -> master)
//   o_random_out  displayed roll value                  (slave  -> master)
//   o_busy        roll in progress                      (slave  -> master)
//   o_done        one-cycle pulse after final capture   (slave  -> master)
// ---------------------------------------------------------------------------
interface roll_sequencer_if #(
    parameter int DATA_W = 4
);
    logic              i_start;
    logic [DATA_W-1:0] i_lfsr_val;
    logic              o_step;
    logic [DATA_W-1:0] o_random_out;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_start,
        output i_lfsr_val,
        input  o_step,
        input  o_random_out,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_lfsr_val,
        output o_step,
        output o_random_out,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/roll_sequencer.sv
// ---------------------------------------------------------------------------
// roll_sequencer
//   Drives a "slot-machine" roll from a free-running LFSR. In IDLE the LFSR is
//   stepped every cycle for entropy. A start request enters RUN, where the LFSR
//   value is captured into the display at intervals that double every
//   STEPS_PER_STAGE captures; after the last capture of the last stage a single
//   DONE cycle pulses o_done and the block returns to IDLE holding the result.
//
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active high
//   bus.i_start    start / restart request
//   bus.i_lfsr_val LFSR value (captured before the LFSR advances)
//   bus.o_step     LFSR advance enable (combinational)
//   bus.o_random_out displayed value (registered)
//   bus.o_busy     high while in RUN (registered)
//   bus.o_done     one-cycle pulse after the final capture (registered)
// ---------------------------------------------------------------------------
module roll_sequencer #(
    parameter int DATA_W          = 4,
    parameter int BASE_INTERVAL   = 4,
    parameter int STEPS_PER_STAGE = 8,
    parameter int NUM_STAGES      = 4,
    parameter int CNT_W           = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    roll_sequencer_if.slave bus
);

    localparam int STEP_W  = (STEPS_PER_STAGE > 1) ? $clog2(STEPS_PER_STAGE + 1) : 1;
    localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [STAGE_W-1:0] stage_q,  stage_d;
    logic [STEP_W-1:0]  steps_q,  steps_d;
    logic [DATA_W-1:0]  random_q, random_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [CNT_W-1:0]   interval_s;
    logic               step_due_s;
    logic               step_raw_s;
    logic               step_s;
    logic               last_step_s;
    logic               last_stage_s;

    // Interval decode and the LFSR advance enable.
    always_comb begin
        interval_s   = CNT_W'(BASE_INTERVAL) << stage_q;
        step_due_s   = (cnt_q == (interval_s - CNT_W'(1)));
        last_step_s  = (steps_q == STEP_W'(STEPS_PER_STAGE - 1));
        last_stage_s = (stage_q == STAGE_W'(NUM_STAGES - 1));
        case (state_q)
            ST_IDLE: step_raw_s = 1'b1;
            // A restart request wins over a step falling in the same cycle.
            ST_RUN:  step_raw_s = step_due_s & ~bus.i_start;
            ST_DONE: step_raw_s = 1'b0;
            default: step_raw_s = 1'b0;
        endcase
        if (i_rst) begin
            step_s = 1'b0;
        end else begin
            step_s = step_raw_s;
        end
    end

    // Next-state, counters and display capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        steps_d  = steps_q;
        random_d = random_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                    stage_d = {STAGE_W{1'b0}};
                    steps_d = {STEP_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.i_start) begin
                    cnt_d   = {CNT_W{1'b0}};
                    stage_d = {STAGE_W{1'b0}};
                    steps_d = {STEP_W{1'b0}};
                end else if (step_due_s) begin
                    // Capture the value the LFSR holds before this advance.
                    random_d = bus.i_lfsr_val;
                    cnt_d    = {CNT_W{1'b0}};
                    if (last_step_s) begin
                        steps_d = {STEP_W{1'b0}};
                        if (last_stage_s) begin
                            state_d = ST_DONE;
                            stage_d = {STAGE_W{1'b0}};
                        end else begin
                            stage_d = stage_q + STAGE_W'(1);
                        end
                    end else begin
                        steps_d = steps_q + STEP_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                cnt_d   = {CNT_W{1'b0}};
                stage_d = {STAGE_W{1'b0}};
                steps_d = {STEP_W{1'b0}};
                if (bus.i_start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                stage_d = {STAGE_W{1'b0}};
                steps_d = {STEP_W{1'b0}};
            end
        endcase
        // Status flags are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            stage_q  <= {STAGE_W{1'b0}};
            steps_q  <= {STEP_W{1'b0}};
            random_q <= {DATA_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            steps_q  <= steps_d;
            random_q <= random_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_step       = step_s;
    assign bus.o_random_out = random_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;

endmodule

// File: tb/tb_roll_sequencer.sv
// Scoreboard bench for roll_sequencer: stimulus pushes expected step cycles,
// captured values, o_done cycles and busy-run lengths; a negedge monitor pops
// and compares them against what the DUT presents.
module tb_roll_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    roll_sequencer_if #(.DATA_W(4)) bus ();
    roll_sequencer dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } step_t;

    step_t step_q[$];
    int    done_q[$];
    int    len_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int special_cyc = -1;
    int run_start   = -1;
    int done_cyc    = 0;

    // Hand-derived interval table for the default parameters.
    int iv[4] = '{4, 8, 16, 32};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] pat(input int c);
        logic [31:0] t;
        if (c == special_cyc) begin
            return 4'hA;
        end
        t = c * 5 + 1;
        return t[3:0];
    endfunction

    // One clock: wait for the edge, then update cycle number and LFSR input.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.i_lfsr_val = pat(cyc);
    endtask

    task automatic adv_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic flush_from(input int r);
        while (step_q.size() > 0 && step_q[$].cyc >= r) void'(step_q.pop_back());
        while (done_q.size() > 0 && done_q[$] >= r) void'(done_q.pop_back());
    endtask

    // Start requested in the current cycle (sampled at the next edge).
    task automatic sched_start();
        int t;
        int len;
        if (run_start >= 0 && cyc > run_start && cyc < done_cyc) begin
            flush_from(cyc);
            void'(len_q.pop_back());
            len = cyc - run_start + 480;
        end else begin
            run_start = cyc;
            len = 480;
        end
        t = cyc;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                t += iv[s];
                step_q.push_back('{t, pat(t)});
            end
        end
        done_cyc = t + 1;
        done_q.push_back(done_cyc);
        len_q.push_back(len);
    endtask

    // Reset asserted in the current cycle while a roll is running.
    task automatic sched_reset();
        flush_from(cyc);
        void'(len_q.pop_back());
        len_q.push_back(cyc - run_start);
        done_cyc = 0;
    endtask

    // Monitor: compares DUT outputs with the scoreboard queues.
    int         busy_cnt = 0;
    logic       val_pend = 1'b0;
    logic [3:0] pend_val = 4'h0;
    always @(negedge clk) begin
        int exp;
        if (val_pend) begin
            chk("capture_val", 32'(bus.o_random_out), 32'(pend_val));
            val_pend = 1'b0;
        end
        while (step_q.size() > 0 && step_q[0].cyc < cyc) begin
            chk("step_missing", 32'(cyc), 32'(step_q[0].cyc));
            void'(step_q.pop_front());
        end
        if (bus.o_busy === 1'b1 && bus.o_step === 1'b1) begin
            exp = (step_q.size() > 0) ? step_q[0].cyc : -1;
            chk("step_time", 32'(cyc), 32'(exp));
            if (exp == cyc) begin
                pend_val = step_q[0].val;
                val_pend = 1'b1;
                void'(step_q.pop_front());
            end
        end
        while (done_q.size() > 0 && done_q[0] < cyc) begin
            chk("done_missing", 32'(cyc), 32'(done_q[0]));
            void'(done_q.pop_front());
        end
        if (bus.o_done === 1'b1) begin
            exp = (done_q.size() > 0) ? done_q[0] : -1;
            chk("done_time", 32'(cyc), 32'(exp));
            if (exp == cyc) void'(done_q.pop_front());
        end
        if (bus.o_busy === 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt > 0) begin
            exp = (len_q.size() > 0) ? len_q.pop_front() : -1;
            chk("busy_len", 32'(busy_cnt), 32'(exp));
            busy_cnt = 0;
        end
    end

    initial begin
        int c0;
        int c1;
        int c2;
        int c3;
        int c4;
        logic [3:0] held;
        bus.i_start    = 1'b0;
        bus.i_lfsr_val = 4'h0;

        // 1: reset held two cycles
        rst = 1'b1;
        repeat (2) begin
            tick();
            chk("rst_step", 32'(bus.o_step), 32'd0);
            chk("rst_disp", 32'(bus.o_random_out), 32'd0);
            chk("rst_busy", 32'(bus.o_busy), 32'd0);
            chk("rst_done", 32'(bus.o_done), 32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("idle_step", 32'(bus.o_step), 32'd1);
        end

        // 2 + 3: full roll, first capture sees 4'hA
        c0 = cyc;
        special_cyc = c0 + 4;
        sched_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        adv_to(c0 + 5);
        chk("cap_A", 32'(bus.o_random_out), 32'hA);
        adv_to(c0 + 482);
        held = pat(c0 + 480);
        repeat (3) begin
            tick();
            chk("final_held", 32'(bus.o_random_out), 32'(held));
            chk("idle_busy", 32'(bus.o_busy), 32'd0);
            chk("idle_step2", 32'(bus.o_step), 32'd1);
        end

        // 4: restart 60 cycles into RUN
        c1 = cyc;
        sched_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        adv_to(c1 + 60);
        sched_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        adv_to(c1 + 60 + 484);
        held = pat(c1 + 60 + 480);
        chk("restart_final", 32'(bus.o_random_out), 32'(held));

        // 5: start coincident with the first step
        c2 = cyc;
        sched_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        adv_to(c2 + 4);
        sched_start();
        bus.i_start = 1'b1;
        #1;
        chk("coinc_step", 32'(bus.o_step), 32'd0);
        tick();
        bus.i_start = 1'b0;
        chk("coinc_nocap", 32'(bus.o_random_out), 32'(held));
        adv_to(c2 + 4 + 484);

        // 6: reset at cycle 200 of a roll, then a bounced start
        c3 = cyc;
        sched_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        adv_to(c3 + 200);
        sched_reset();
        rst = 1'b1;
        #1;
        chk("midrst_step", 32'(bus.o_step), 32'd0);
        tick();
        rst = 1'b0;
        chk("midrst_disp", 32'(bus.o_random_out), 32'd0);
        chk("midrst_busy", 32'(bus.o_busy), 32'd0);
        chk("midrst_done", 32'(bus.o_done), 32'd0);
        repeat (4) tick();

        c4 = cyc;
        sched_start();
        bus.i_start = 1'b1;
        tick();
        sched_start();
        tick();
        bus.i_start = 1'b0;
        adv_to(c4 + 1 + 484);
        chk("bounce_final", 32'(bus.o_random_out), 32'(pat(c4 + 1 + 480)));

        repeat (4) tick();
        chk("steps_left", 32'(step_q.size()), 32'd0);
        chk("dones_left", 32'(done_q.size()), 32'd0);
        chk("lens_left", 32'(len_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
